pulse_stim_gen: RTL
===================

Name: pulse_stim_gen

Overview:
Synthesizable stimulus source for the context-inferred signal checkers. It drives a single test signal with programmable low/high pulse trains, so that every pulse satisfies "!sig ##1 sig" under a deasserted reset. It sits beside the checked module, in place of the ad-hoc always-block drivers. It also counts the sequence matches it produces, so cover results can be cross-checked against hardware.

Parameters:
LEN_W, 8, width of low/high phase length fields.
REP_W, 8, width of the repeat-count field.
HIT_W, 16, width of the saturating hit counter.

Ports:
clk  in  1  single clock, all state updated on posedge.
rst  in  1  synchronous reset, active-low (0 = reset).
en  in  1  gating enable; low freezes all state and test_sig.
start  in  1  one-cycle request; accepted only in IDLE with en=1.
low_len  in  LEN_W  cycles test_sig is held 0 per pulse.
high_len  in  LEN_W  cycles test_sig is held 1 per pulse.
rep_cnt  in  REP_W  number of pulses per run.
busy  out  1  high from the cycle after start is accepted until DONE is exited.
done  out  1  one-cycle completion strobe.
test_sig  out  1  generated stimulus.
hit_cnt  out  HIT_W  count of 0->1 transitions of test_sig made while rst=1; saturates.

Behaviour:
- Reset (rst=0 at posedge): state=IDLE. busy=0, done=0, test_sig=0, hit_cnt=0. All latched config and counters are cleared. Reset mid-run aborts immediately; no done strobe is produced.
- States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - On start & en, latch low_len, high_len and rep_cnt.
  - Zero lengths are clamped to 1. This guarantees at least one low cycle before each rise.
  - If the latched rep_cnt is 0, go to DONE; otherwise go to LOW with phase counter = low_len, rep counter = rep_cnt.
  - start while not IDLE is ignored.
- LOW: test_sig=0. Decrement the phase counter each enabled cycle. When it reaches 1, go to HIGH and load high_len.
- HIGH: test_sig=1. On entry (the 0->1 edge), hit_cnt += 1, saturating at all-ones. When the phase counter reaches 1, decrement the rep counter.
  - If reps remain, go to LOW (reload low_len).
  - Else go to DONE.
- DONE: done=1 for exactly one enabled cycle, test_sig=0, then go to IDLE. busy drops in the same cycle the FSM returns to IDLE.
- Timing for a run with low_len=L, high_len=H, rep_cnt=R (R>0):
  - test_sig is low for L cycles, then high for H cycles, per pulse.
  - The first low cycle is the cycle after start is accepted.
  - done is asserted R*(L+H)+1 cycles after acceptance.
- en=0: state, counters, hit_cnt and test_sig all hold. done is held as well; the strobe is emitted on the first enabled cycle of DONE.
- Changes to config inputs while busy have no effect.
- Output registers: test_sig, done, busy and hit_cnt are flop outputs with no combinational path from inputs.

Optional Feature:
PULSE_STIM_GEN_ABORT_EN
- When defined: adds input port abort (1 bit).
  - abort=1 with en=1 in LOW or HIGH forces test_sig=0 and moves to DONE next cycle; done strobes as normal.
  - abort in IDLE or DONE is ignored. abort has priority over phase expiry in the same cycle.
- When undefined: no abort port, and runs always complete.

Decomposition:
- Package pulse_stim_gen_pkg:
  - state enum typedef (IDLE, LOW, HIGH, DONE, 2-bit encoding).
  - default width localparams.
  - clamp-to-one helper function.
- Sub-module pulse_stim_gen_cnt: loadable down-counter with enable, load and expiry (==1) flag. It is instantiated twice: phase counter and rep counter.
- FSM and hit counter stay in the top module.

Test Plan:
- Reset: hold rst=0 for 3 cycles with start=1 -> busy=0, done=0, test_sig=0, hit_cnt=0 throughout.
- Basic run: low_len=2, high_len=3, rep_cnt=2, start pulse -> test_sig pattern 0,0,1,1,1,0,0,1,1,1. done asserted 11 cycles after acceptance; hit_cnt=2.
- Zero clamps: low_len=0, high_len=0, rep_cnt=3 -> alternating 0,1 x3; hit_cnt=3. rep_cnt=0 -> done on cycle 1 and no rise.
- Enable gating: basic run with en=0 for 4 cycles in the middle of HIGH -> test_sig held 1, the high phase is extended by 4 cycles, and done is delayed by 4 cycles.
- Mid-run reset: rst=0 during the second LOW phase -> next cycle IDLE, test_sig=0, hit_cnt=0, no done strobe. A following start runs normally.
- Saturation and abort: with HIT_W=2, run rep_cnt=5 -> hit_cnt stops at 3. With PULSE_STIM_GEN_ABORT_EN defined, abort in the first HIGH -> test_sig=0 and done strobe on the next cycle.

Source files
------------

// File: rtl/pulse_stim_gen_pkg.sv
// Shared types and helpers for the pulse stimulus generator.
package pulse_stim_gen_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLow  = 2'd1,
    StHigh = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam int unsigned DefLenW = 8;
  localparam int unsigned DefRepW = 8;
  localparam int unsigned DefHitW = 16;

  // Zero-length phases would break the "!sig ##1 sig" guarantee, so they run as one cycle.
  function automatic logic [31:0] clamp_to_one(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/pulse_stim_gen_cnt.sv
// Loadable down-counter with enable; expired_o flags a count of exactly one.
module pulse_stim_gen_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             expired_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (en_i) begin
      if (load_i) begin
        cnt_q <= load_val_i;
      end else if (dec_i) begin
        cnt_q <= cnt_q - Width'(1);
      end
    end
  end

  assign expired_o = (cnt_q == Width'(1));

endmodule

// File: rtl/pulse_stim_gen.sv
// Programmable low/high pulse-train generator with a saturating rise counter.
// Optional abort input enabled by defining PULSE_STIM_GEN_ABORT_EN.
module pulse_stim_gen
  import pulse_stim_gen_pkg::*;
#(
  parameter int unsigned LEN_W = DefLenW,
  parameter int unsigned REP_W = DefRepW,
  parameter int unsigned HIT_W = DefHitW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             start_i,
`ifdef PULSE_STIM_GEN_ABORT_EN
  input  logic             abort_i,
`endif
  input  logic [LEN_W-1:0] low_len_i,
  input  logic [LEN_W-1:0] high_len_i,
  input  logic [REP_W-1:0] rep_cnt_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             test_sig_o,
  output logic [HIT_W-1:0] hit_cnt_o
);

  state_e state_q, state_d;

  logic [LEN_W-1:0] low_len_q, high_len_q;
  logic [LEN_W-1:0] low_clamped, high_clamped;
  logic             cfg_latch;

  logic             phase_load, phase_dec, phase_exp;
  logic [LEN_W-1:0] phase_val;
  logic             rep_load, rep_dec, rep_exp;

  logic             busy_q, done_q, test_sig_q;
  logic [HIT_W-1:0] hit_cnt_q;
  logic             abort;

`ifdef PULSE_STIM_GEN_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  assign low_clamped  = LEN_W'(clamp_to_one(32'(low_len_i)));
  assign high_clamped = LEN_W'(clamp_to_one(32'(high_len_i)));

  always_comb begin
    state_d    = state_q;
    cfg_latch  = 1'b0;
    phase_load = 1'b0;
    phase_dec  = 1'b0;
    phase_val  = '0;
    rep_load   = 1'b0;
    rep_dec    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cfg_latch = 1'b1;
          if (rep_cnt_i == '0) begin
            state_d = StDone;
          end else begin
            state_d    = StLow;
            phase_load = 1'b1;
            phase_val  = low_clamped;
            rep_load   = 1'b1;
          end
        end
      end
      StLow: begin
        if (abort) begin
          state_d = StDone;
        end else if (phase_exp) begin
          state_d    = StHigh;
          phase_load = 1'b1;
          phase_val  = high_len_q;
        end else begin
          phase_dec = 1'b1;
        end
      end
      StHigh: begin
        if (abort) begin
          state_d = StDone;
        end else if (phase_exp) begin
          if (rep_exp) begin
            state_d = StDone;
          end else begin
            state_d    = StLow;
            phase_load = 1'b1;
            phase_val  = low_len_q;
            rep_dec    = 1'b1;
          end
        end else begin
          phase_dec = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  pulse_stim_gen_cnt #(
    .Width (LEN_W)
  ) u_phase_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .load_i     (phase_load),
    .load_val_i (phase_val),
    .dec_i      (phase_dec),
    .expired_o  (phase_exp)
  );

  pulse_stim_gen_cnt #(
    .Width (REP_W)
  ) u_rep_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .load_i     (rep_load),
    .load_val_i (rep_cnt_i),
    .dec_i      (rep_dec),
    .expired_o  (rep_exp)
  );

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      low_len_q  <= '0;
      high_len_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      test_sig_q <= 1'b0;
      hit_cnt_q  <= '0;
    end else if (en_i) begin
      state_q    <= state_d;
      busy_q     <= (state_d != StIdle);
      done_q     <= (state_d == StDone);
      test_sig_q <= (state_d == StHigh);
      if (cfg_latch) begin
        low_len_q  <= low_clamped;
        high_len_q <= high_clamped;
      end
      if ((state_d == StHigh) && (state_q != StHigh) && (hit_cnt_q != {HIT_W{1'b1}})) begin
        hit_cnt_q <= hit_cnt_q + HIT_W'(1);
      end
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign test_sig_o = test_sig_q;
  assign hit_cnt_o  = hit_cnt_q;

endmodule
